// File: rtl/dp_pkg.sv
// Shared definitions for the sequenced datapath: ALU function codes,
// FSM state encoding and a constant-evaluable clog2.
package dp_pkg;

   localparam logic [3:0] FS_A     = 4'h0;
   localparam logic [3:0] FS_INC   = 4'h1;
   localparam logic [3:0] FS_ADD   = 4'h2;
   localparam logic [3:0] FS_ADDC  = 4'h3;
   localparam logic [3:0] FS_ADDNB = 4'h4;
   localparam logic [3:0] FS_SUB   = 4'h5;
   localparam logic [3:0] FS_DEC   = 4'h6;
   localparam logic [3:0] FS_A2    = 4'h7;
   localparam logic [3:0] FS_AND   = 4'h8;
   localparam logic [3:0] FS_OR    = 4'h9;
   localparam logic [3:0] FS_XOR   = 4'hA;
   localparam logic [3:0] FS_NOTA  = 4'hB;
   localparam logic [3:0] FS_B     = 4'hC;
   localparam logic [3:0] FS_SHR   = 4'hD;
   localparam logic [3:0] FS_SHL   = 4'hE;
   localparam logic [3:0] FS_B2    = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_EXEC     = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_WB       = 2'd3
   } state_e;

   // Smallest r with 2**r >= value; used to size register/memory addresses.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU. Codes 0-7 share one WIDTH+1 bit adder (A + addend + cin)
// so carry and signed overflow fall out of a single sum; codes 8-15 are
// logic/shift ops and report V=C=0.
module dp_alu
   import dp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [3:0]       fs_i,
   output logic [WIDTH-1:0] result_o,
   output logic             v_o,
   output logic             c_o
);

   logic [WIDTH-1:0] addend;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic             arith;

   // Select the adder's second operand and carry-in for the arithmetic codes.
   always_comb begin
      addend = '0;
      cin    = 1'b0;
      case (fs_i)
         FS_INC:   cin = 1'b1;
         FS_ADD:   addend = b_i;
         FS_ADDC:  begin addend = b_i;  cin = 1'b1; end
         FS_ADDNB: addend = ~b_i;
         FS_SUB:   begin addend = ~b_i; cin = 1'b1; end
         FS_DEC:   addend = '1;
         default:  ;
      endcase
   end

   assign arith = ~fs_i[3];
   assign sum   = {1'b0, a_i} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};

   // Final result mux; shifts are WIDTH-wide with zero fill.
   always_comb begin
      result_o = sum[WIDTH-1:0];
      case (fs_i)
         FS_AND:        result_o = a_i & b_i;
         FS_OR:         result_o = a_i | b_i;
         FS_XOR:        result_o = a_i ^ b_i;
         FS_NOTA:       result_o = ~a_i;
         FS_B, FS_B2:   result_o = b_i;
         FS_SHR:        result_o = {1'b0, b_i[WIDTH-1:1]};
         FS_SHL:        result_o = {b_i[WIDTH-2:0], 1'b0};
         default:       result_o = sum[WIDTH-1:0];
      endcase
   end

   // Overflow: both adder inputs share a sign that the sum does not.
   assign v_o = arith & (a_i[WIDTH-1] == addend[WIDTH-1]) & (sum[WIDTH-1] != a_i[WIDTH-1]);
   assign c_o = arith & sum[WIDTH];

endmodule

// File: rtl/datapath_mem_seq.sv
// Sequenced register file + ALU + data memory. One op in flight at a time:
// IDLE accepts, EXEC computes/stores, optional MEM_WAIT models load latency,
// WB writes back. Operands are captured at accept, so no hazards exist.
module datapath_mem_seq
   import dp_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  int NREGS     = 4,
   parameter  int MEM_DEPTH = 256,
   parameter  int MEM_LAT   = 2,
   localparam int RA_W      = clog2(NREGS),
   localparam int MA_W      = clog2(MEM_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [RA_W-1:0]  DA,
   input  logic [RA_W-1:0]  AA,
   input  logic [RA_W-1:0]  BA,
   input  logic [WIDTH-1:0] constant,
   input  logic             MB,
   input  logic             RW,
   input  logic             MD,
   input  logic             MW,
   input  logic [3:0]       FS,
   output logic             V,
   output logic             C,
   output logic             N,
   output logic             Z,
   output logic             done,
   output logic [WIDTH-1:0] jump_address,
   output logic [WIDTH-1:0] data_out
);

   localparam logic [3:0] LAT = 4'(MEM_LAT);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [RA_W-1:0]  da;
      logic [3:0]       fs;
      logic             rw;
      logic             md;
      logic             mw;
   } op_t;

   state_e                       state_q, state_d;
   logic [3:0]                   cnt_q, cnt_d;
   op_t                          op_q;
   logic [NREGS-1:0][WIDTH-1:0]  regs_q;
   logic [WIDTH-1:0]             mem [MEM_DEPTH];
   logic [WIDTH-1:0]             alu_res, alu_q, load_q, wb_res;
   logic [WIDTH-1:0]             a_sel, b_sel;
   logic                         alu_v, alu_c;
   logic                         accept, md_eff, store_en;
   logic [MA_W-1:0]              addr;

   assign op_ready = (state_q == ST_IDLE);
   assign accept   = op_valid & op_ready;
   assign done     = (state_q == ST_WB);
   assign a_sel    = regs_q[AA];
   assign b_sel    = MB ? constant : regs_q[BA];
   // A store wins over a load when both are requested.
   assign md_eff   = op_q.md & ~op_q.mw;
   assign addr     = op_q.a[MA_W-1:0];
   assign wb_res   = md_eff ? load_q : alu_q;
   // A store on the same edge that reset is asserted must not land.
   assign store_en = (state_q == ST_EXEC) & op_q.mw & ~rst;

   dp_alu #(.WIDTH(WIDTH)) u_alu (
      .a_i      (op_q.a),
      .b_i      (op_q.b),
      .fs_i     (op_q.fs),
      .result_o (alu_res),
      .v_o      (alu_v),
      .c_o      (alu_c)
   );

   // Next-state and wait-counter logic; counter runs MEM_LAT down to 1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_EXEC;
         ST_EXEC: begin
            if (md_eff && (LAT != 4'd0)) begin
               state_d = ST_MEM_WAIT;
               cnt_d   = LAT;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM_WAIT: begin
            if (cnt_q == 4'd1) state_d = ST_WB;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state and wait counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Capture operands and control at accept; A also drives jump_address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q         <= '0;
         jump_address <= '0;
      end else if (accept) begin
         op_q         <= '{a: a_sel, b: b_sel, da: DA, fs: FS, rw: RW, md: MD, mw: MW};
         jump_address <= a_sel;
      end
   end

   // Register ALU result and flags in EXEC; sample load data entering WB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_q  <= '0;
         load_q <= '0;
         V      <= 1'b0;
         C      <= 1'b0;
         N      <= 1'b0;
         Z      <= 1'b0;
      end else begin
         if (state_q == ST_EXEC) begin
            alu_q <= alu_res;
            V     <= alu_v;
            C     <= alu_c;
            N     <= alu_res[WIDTH-1];
            Z     <= (alu_res == '0);
         end
         if (state_d == ST_WB) load_q <= mem[addr];
      end
   end

   // Write-back on the edge leaving WB: data_out always, register if RW.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q   <= '0;
         data_out <= '0;
      end else if (state_q == ST_WB) begin
         data_out <= wb_res;
         if (op_q.rw) regs_q[op_q.da] <= wb_res;
      end
   end

   // Data memory; deliberately not reset so contents survive a reset.
   always_ff @(posedge clk) begin
      if (store_en) mem[addr] <= op_q.b;
   end

endmodule

// File: tb/tb_datapath_mem_seq.sv
// Directed bench with a reference model and scoreboard for datapath_mem_seq.
module tb_datapath_mem_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       op_valid, op_ready;
   logic [1:0] DA, AA, BA;
   logic [7:0] constant;
   logic       MB, RW, MD, MW;
   logic [3:0] FS;
   logic       V, C, N, Z, done;
   logic [7:0] jump_address, data_out;

   always #5 clk = ~clk;

   datapath_mem_seq #(.WIDTH(8), .NREGS(4), .MEM_DEPTH(256), .MEM_LAT(2)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
      .DA(DA), .AA(AA), .BA(BA), .constant(constant),
      .MB(MB), .RW(RW), .MD(MD), .MW(MW), .FS(FS),
      .V(V), .C(C), .N(N), .Z(Z), .done(done),
      .jump_address(jump_address), .data_out(data_out)
   );

   typedef struct {
      logic [1:0] da, aa, ba;
      logic [7:0] k;
      logic       mb, rw, md, mw;
      logic [3:0] fs;
   } op_t;

   typedef struct {
      logic [7:0] data;
      logic [3:0] flags;
      logic [7:0] jaddr;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       cur;
   logic [7:0] m_regs [4];
   logic [7:0] m_mem  [256];
   int         tests  = 0;
   int         fails  = 0;
   int         n_done = 0;
   bit         pend   = 1'b0;

   // Reference ALU written per function code from the arithmetic definitions.
   function automatic void alu_model(input logic [3:0] fs, input logic [7:0] a, b,
                                     output logic [7:0] r, output logic v, c);
      logic [8:0] s;
      s = '0; r = '0; v = 1'b0; c = 1'b0;
      case (fs)
         4'd0, 4'd7: r = a;
         4'd1:  begin s = a + 9'd1;            v = (a == 8'h7F); end
         4'd2:  begin s = a + b;               v = (a[7] == b[7]) && (s[7] != a[7]); end
         4'd3:  begin s = a + b + 9'd1;        v = (a[7] == b[7]) && (s[7] != a[7]); end
         4'd4:  begin s = a + {1'b0, ~b};      v = (a[7] != b[7]) && (s[7] != a[7]); end
         4'd5:  begin s = a + {1'b0, ~b} + 9'd1; v = (a[7] != b[7]) && (s[7] != a[7]); end
         4'd6:  begin s = a + 9'h0FF;          v = (a == 8'h80); end
         4'd8:  r = a & b;
         4'd9:  r = a | b;
         4'd10: r = a ^ b;
         4'd11: r = ~a;
         4'd13: r = b >> 1;
         4'd14: r = b << 1;
         default: r = b;
      endcase
      if (fs >= 4'd1 && fs <= 4'd6) begin
         r = s[7:0];
         c = s[8];
      end
   endfunction

   function automatic op_t mk(input logic [3:0] fs, input logic [1:0] da, aa, ba,
                              input logic [7:0] k, input logic mb, rw, md, mw);
      op_t o;
      o.fs = fs; o.da = da; o.aa = aa; o.ba = ba; o.k = k;
      o.mb = mb; o.rw = rw; o.md = md; o.mw = mw;
      return o;
   endfunction

   task automatic drive(input op_t o);
      DA = o.da; AA = o.aa; BA = o.ba; constant = o.k;
      MB = o.mb; RW = o.rw; MD = o.md; MW = o.mw; FS = o.fs;
   endtask

   // Apply op to the model and queue the expected write-back/flags.
   task automatic push_op(input op_t o);
      logic [7:0] a, b, r, res;
      logic       v, c;
      exp_t       e;
      a = m_regs[o.aa];
      b = o.mb ? o.k : m_regs[o.ba];
      alu_model(o.fs, a, b, r, v, c);
      if (o.mw) m_mem[a] = b;
      res = (o.md && !o.mw) ? m_mem[a] : r;
      if (o.rw) m_regs[o.da] = res;
      e.data  = res;
      e.flags = {v, c, r[7], (r == 8'h00)};
      e.jaddr = a;
      sb_q.push_back(e);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Issue one op, return accept->done latency and cycles with op_ready low.
   task automatic do_op(input op_t o, output int lat, output int rdy_low);
      int n;
      n = 0;
      while (!op_ready && n < 100) begin @(negedge clk); n++; end
      drive(o);
      op_valid = 1'b1;
      push_op(o);
      @(posedge clk);
      #1 op_valid = 1'b0;
      lat = 0; rdy_low = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!op_ready) rdy_low++;
      end while (!done && lat < 40);
   endtask

   // Scoreboard: flags/jump_address checked in WB, data_out the cycle after.
   always @(negedge clk) begin
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            pend = 1'b0;
            tests++;
            assert (data_out === cur.data) else begin
               fails++;
               $error("FAIL sb_data: got %0h want %0h", data_out, cur.data);
            end
         end
         if (done) begin
            if (sb_q.size() == 0) begin
               tests++; fails++;
               $error("FAIL sb_unexpected_done: got done=1 want no done");
            end else begin
               cur = sb_q.pop_front();
               n_done++;
               tests++;
               assert ({V, C, N, Z} === cur.flags) else begin
                  fails++;
                  $error("FAIL sb_flags: got %b want %b", {V, C, N, Z}, cur.flags);
               end
               tests++;
               assert (jump_address === cur.jaddr) else begin
                  fails++;
                  $error("FAIL sb_jaddr: got %0h want %0h", jump_address, cur.jaddr);
               end
               pend = 1'b1;
            end
         end
      end
   end

   initial begin
      int  lat, rl, nacc, d0, n;
      op_t o;
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      op_valid = 1'b0;
      drive(mk(4'h0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(op_ready), 32'd1);
      check("rst_flags", 32'({V, C, N, Z}), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_jaddr", 32'(jump_address), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);

      // 1: load constant 0x7F into R1
      do_op(mk(4'hC, 2'd1, 2'd0, 2'd0, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0), lat, rl);
      check("t1_lat", 32'(lat), 32'd2);
      check("t1_flags", 32'({V, C, N, Z}), 32'b0000);
      @(negedge clk);
      check("t1_data", 32'(data_out), 32'h7F);

      // 2: R2 = R1+1 overflows; then 0x80-0x80
      do_op(mk(4'h1, 2'd2, 2'd1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), lat, rl);
      check("t2_inc_flags", 32'({V, C, N, Z}), 32'b1010);
      do_op(mk(4'h5, 2'd0, 2'd2, 2'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), lat, rl);
      check("t2_sub_flags", 32'({V, C, N, Z}), 32'b0101);
      @(negedge clk);
      check("t2_sub_data", 32'(data_out), 32'h00);

      // 3: store R1 at R0, load it back into R3
      do_op(mk(4'hC, 2'd0, 2'd0, 2'd0, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0), lat, rl);
      do_op(mk(4'hC, 2'd1, 2'd0, 2'd0, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0), lat, rl);
      do_op(mk(4'h0, 2'd0, 2'd0, 2'd1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1), lat, rl);
      check("t3_store_lat", 32'(lat), 32'd2);
      do_op(mk(4'h0, 2'd3, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0), lat, rl);
      check("t3_load_lat", 32'(lat), 32'd4);
      check("t3_ready_low", 32'(rl), 32'd4);
      do_op(mk(4'h0, 2'd0, 2'd3, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), lat, rl);
      @(negedge clk);
      check("t3_r3", 32'(data_out), 32'h5A);

      // 4: op_valid held high with fields changing every cycle
      n = 0;
      while (!op_ready && n < 20) begin @(negedge clk); n++; end
      d0 = n_done; nacc = 0;
      op_valid = 1'b1;
      for (int i = 0; i < 15; i++) begin
         o = mk(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, 1'b0);
         drive(o);
         if (op_ready) begin
            push_op(o);
            nacc++;
         end
         @(negedge clk);
      end
      op_valid = 1'b0;
      n = 0;
      while ((sb_q.size() != 0 || pend) && n < 50) begin @(negedge clk); n++; end
      check("t4_accepts", 32'(nacc), 32'd5);
      check("t4_dones", 32'(n_done - d0), 32'(nacc));

      // 5: reset in the MEM_WAIT of a load
      n = 0;
      while (!op_ready && n < 20) begin @(negedge clk); n++; end
      drive(mk(4'h0, 2'd2, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
      op_valid = 1'b1;
      @(posedge clk);
      #1 op_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("t5_in_wait", 32'(op_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      check("t5_ready", 32'(op_ready), 32'd1);
      check("t5_flags", 32'({V, C, N, Z}), 32'd0);
      check("t5_data", 32'(data_out), 32'd0);
      check("t5_jaddr", 32'(jump_address), 32'd0);
      do_op(mk(4'h0, 2'd0, 2'd2, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), lat, rl);
      @(negedge clk);
      check("t5_r2", 32'(data_out), 32'h00);
      do_op(mk(4'hC, 2'd0, 2'd0, 2'd0, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0), lat, rl);
      do_op(mk(4'h0, 2'd3, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0), lat, rl);
      @(negedge clk);
      check("t5_mem_kept", 32'(data_out), 32'h5A);

      // 6: MW and MD together at A=0xFF behave as a store
      do_op(mk(4'hC, 2'd1, 2'd0, 2'd0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0), lat, rl);
      do_op(mk(4'h0, 2'd2, 2'd1, 2'd0, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1), lat, rl);
      check("t6_lat", 32'(lat), 32'd2);
      check("t6_jaddr", 32'(jump_address), 32'hFF);
      @(negedge clk);
      check("t6_data", 32'(data_out), 32'hFF);
      do_op(mk(4'h0, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0), lat, rl);
      check("t6_load_lat", 32'(lat), 32'd4);
      @(negedge clk);
      check("t6_load", 32'(data_out), 32'h33);

      n = 0;
      while ((sb_q.size() != 0 || pend) && n < 50) begin @(negedge clk); n++; end
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
